// File: rtl/uart_f2c_wb_bridge.sv
// Fabric-to-core slave bridge: buffers F2C requests in a small FIFO and runs
// each one as a single wishbone classic cycle, returning an F2C response.
module uart_f2c_wb_bridge #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F2C_ReqValidQ502H,
  input  logic [1:0]        F2C_ReqOpcodeQ502H,
  input  logic [31:0]       F2C_ReqAddressQ502H,
  input  logic [31:0]       F2C_ReqDataQ502H,
  output logic              F2C_ReqStall,
  output logic              F2C_RspValidQ500H,
  output logic [1:0]        F2C_RspOpcodeQ500H,
  output logic [31:0]       F2C_RspAddressQ500H,
  output logic [31:0]       F2C_RspDataQ500H,
  input  logic              F2C_RspStall,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_RD     = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b10;
  localparam logic [1:0] OP_RD_RSP = 2'b01;
  localparam logic [1:0] OP_WR_RSP = 2'b11;

  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]     TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RSP
  } state_t;

  state_t state;

  logic             fifo_we   [FIFO_DEPTH];
  logic [31:0]      fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [15:0]      tmo_cnt;

  logic op_legal;
  logic push;
  logic pop;

  assign op_legal = (F2C_ReqOpcodeQ502H == OP_RD) || (F2C_ReqOpcodeQ502H == OP_WR);
  assign push     = F2C_ReqValidQ502H && !F2C_ReqStall && op_legal;
  assign pop      = (state == S_IDLE) && (count != '0);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      F2C_ReqStall <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      F2C_ReqStall <= (count_next == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]   <= (F2C_ReqOpcodeQ502H == OP_WR);
      fifo_addr[wr_ptr] <= F2C_ReqAddressQ502H;
      fifo_data[wr_ptr] <= F2C_ReqDataQ502H;
    end
  end

  // Response opcode/address are latched at pop time so they are already
  // stable when RspValid rises; wb_we_o doubles as the current op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      tmo_cnt             <= '0;
      wb_cyc_o            <= 1'b0;
      wb_stb_o            <= 1'b0;
      wb_we_o             <= 1'b0;
      wb_adr_o            <= '0;
      wb_dat_o            <= '0;
      wb_sel_o            <= '0;
      F2C_RspValidQ500H   <= 1'b0;
      F2C_RspOpcodeQ500H  <= '0;
      F2C_RspAddressQ500H <= '0;
      F2C_RspDataQ500H    <= '0;
      timeout_err         <= 1'b0;
    end else begin
      wb_sel_o    <= '1;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            wb_cyc_o            <= 1'b1;
            wb_stb_o            <= 1'b1;
            wb_we_o             <= fifo_we[rd_ptr];
            wb_adr_o            <= fifo_addr[rd_ptr][ADDR_W-1:0];
            wb_dat_o            <= DATA_W'(fifo_data[rd_ptr]);
            F2C_RspOpcodeQ500H  <= fifo_we[rd_ptr] ? OP_WR_RSP : OP_RD_RSP;
            F2C_RspAddressQ500H <= fifo_addr[rd_ptr];
            tmo_cnt             <= '0;
            state               <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o          <= 1'b0;
            wb_stb_o          <= 1'b0;
            wb_we_o           <= 1'b0;
            F2C_RspValidQ500H <= 1'b1;
            F2C_RspDataQ500H  <= wb_we_o ? '0 : 32'(wb_dat_i);
            state             <= S_RSP;
          end else if (tmo_cnt == TMO_LAST) begin
            wb_cyc_o          <= 1'b0;
            wb_stb_o          <= 1'b0;
            wb_we_o           <= 1'b0;
            F2C_RspValidQ500H <= 1'b1;
            F2C_RspDataQ500H  <= TMO_DATA;
            timeout_err       <= 1'b1;
            state             <= S_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RSP: begin
          if (!F2C_RspStall) begin
            F2C_RspValidQ500H <= 1'b0;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_f2c_wb_bridge.sv
// Directed bench for uart_f2c_wb_bridge: one instance with a long timeout for
// the protocol tests and one with TIMEOUT=8 for the timeout path.
module tb_uart_f2c_wb_bridge;

  localparam logic [1:0] OP_RD     = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b10;
  localparam logic [1:0] OP_RD_RSP = 2'b01;
  localparam logic [1:0] OP_WR_RSP = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_valid_t;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic        rsp_stall;
  logic [31:0] wb_dat;
  logic        wb_ack;

  logic        req_stall, rsp_valid, cyc, stb, we, tmo_err;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_addr, rsp_data, dat_o;
  logic [7:0]  adr;
  logic [3:0]  sel;

  logic        t_req_stall, t_rsp_valid, t_cyc, t_stb, t_we, t_tmo_err;
  logic [1:0]  t_rsp_op;
  logic [31:0] t_rsp_addr, t_rsp_data, t_dat_o;
  logic [7:0]  t_adr;
  logic [3:0]  t_sel;

  int n_checks = 0;
  int n_fail   = 0;

  uart_f2c_wb_bridge #(.ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .F2C_ReqValidQ502H(req_valid), .F2C_ReqOpcodeQ502H(req_op),
    .F2C_ReqAddressQ502H(req_addr), .F2C_ReqDataQ502H(req_data),
    .F2C_ReqStall(req_stall),
    .F2C_RspValidQ500H(rsp_valid), .F2C_RspOpcodeQ500H(rsp_op),
    .F2C_RspAddressQ500H(rsp_addr), .F2C_RspDataQ500H(rsp_data),
    .F2C_RspStall(rsp_stall),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
    .timeout_err(tmo_err)
  );

  uart_f2c_wb_bridge #(.ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst),
    .F2C_ReqValidQ502H(req_valid_t), .F2C_ReqOpcodeQ502H(req_op),
    .F2C_ReqAddressQ502H(req_addr), .F2C_ReqDataQ502H(req_data),
    .F2C_ReqStall(t_req_stall),
    .F2C_RspValidQ500H(t_rsp_valid), .F2C_RspOpcodeQ500H(t_rsp_op),
    .F2C_RspAddressQ500H(t_rsp_addr), .F2C_RspDataQ500H(t_rsp_data),
    .F2C_RspStall(rsp_stall),
    .wb_cyc_o(t_cyc), .wb_stb_o(t_stb), .wb_we_o(t_we), .wb_adr_o(t_adr),
    .wb_dat_o(t_dat_o), .wb_sel_o(t_sel), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
    .timeout_err(t_tmo_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the request up for exactly one posedge.
  task automatic send_req(input logic to_t, input logic [1:0] op,
                          input logic [31:0] addr, input logic [31:0] data);
    req_op   = op;
    req_addr = addr;
    req_data = data;
    if (to_t) req_valid_t = 1'b1;
    else      req_valid   = 1'b1;
    @(negedge clk);
    req_valid   = 1'b0;
    req_valid_t = 1'b0;
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    while (!cyc && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, cyc, 1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, rsp_valid, 1);
  endtask

  task automatic give_ack(input int dly, input logic [31:0] d);
    repeat (dly) @(negedge clk);
    wb_ack = 1'b1;
    wb_dat = d;
    @(negedge clk);
    wb_ack = 1'b0;
    wb_dat = '0;
  endtask

  logic        stall_seen;
  logic        seen;
  logic [1:0]  h_op;
  logic [31:0] h_addr, h_data;
  int          n_cyc, n_err, n_rsp;

  initial begin
    rst = 1'b1; req_valid = 0; req_valid_t = 0; req_op = '0; req_addr = '0;
    req_data = '0; rsp_stall = 0; wb_dat = '0; wb_ack = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_cyc", cyc, 0);
    check_eq("rst_stb", stb, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_adr", adr, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_stall", req_stall, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_tmo_err", tmo_err, 0);
    check_eq("rst_t_rsp_valid", t_rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write with ack in the third BUS cycle
    send_req(0, OP_WR, 32'h0000_0003, 32'h41);
    wait_cyc("wr_wait_cyc");
    check_eq("wr_stb", stb, 1);
    check_eq("wr_we", we, 1);
    check_eq("wr_adr", adr, 8'h03);
    check_eq("wr_dat_o", dat_o, 32'h41);
    check_eq("wr_sel", sel, 4'hF);
    give_ack(2, 32'hFFFF_FFFF);
    wait_rsp("wr_wait_rsp");
    check_eq("wr_rsp_op", rsp_op, OP_WR_RSP);
    check_eq("wr_rsp_addr", rsp_addr, 32'h3);
    check_eq("wr_rsp_data", rsp_data, 32'h0);
    check_eq("wr_cyc_dropped", cyc, 0);
    repeat (2) @(negedge clk);

    // Read with immediate ack: exact latency
    send_req(0, OP_RD, 32'h05, 32'h0);
    check_eq("rd_cyc_n1", cyc, 0);
    @(negedge clk);
    check_eq("rd_cyc_n2", cyc, 1);
    check_eq("rd_we", we, 0);
    check_eq("rd_adr", adr, 8'h05);
    wb_ack = 1'b1; wb_dat = 32'h60;
    @(negedge clk);
    wb_ack = 1'b0; wb_dat = '0;
    check_eq("rd_rsp_valid_n3", rsp_valid, 1);
    check_eq("rd_rsp_op", rsp_op, OP_RD_RSP);
    check_eq("rd_rsp_addr", rsp_addr, 32'h5);
    check_eq("rd_rsp_data", rsp_data, 32'h60);
    @(negedge clk);
    check_eq("rd_rsp_valid_drop", rsp_valid, 0);

    // Illegal opcode is never pushed
    send_req(0, 2'b01, 32'h30, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cyc || rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("bad_op_dropped", seen, 0);

    // Back-pressure: 6 writes, no ack for 20 cycles
    stall_seen = 1'b0;
    fork
      begin : push_side
        int i;
        int guard;
        logic acc;
        i = 0; guard = 0;
        while (i < 6 && guard < 200) begin
          req_op = OP_WR; req_addr = 32'h20 + i; req_data = 32'hA0 + i;
          req_valid = 1'b1;
          acc = !req_stall;
          if (req_stall) stall_seen = 1'b1;
          @(negedge clk);
          guard++;
          if (acc) i++;
        end
        req_valid = 1'b0;
        check_eq("bp_pushed", i, 6);
      end
      begin : slave_side
        wait_cyc("bp_first_cyc");
        repeat (20) @(negedge clk);
        check_eq("bp_still_waiting", cyc, 1);
        check_eq("bp_no_rsp_yet", rsp_valid, 0);
        check_eq("bp_stall_full", req_stall, 1);
        for (int k = 0; k < 6; k++) begin
          wait_cyc("bp_wait_cyc");
          check_eq("bp_adr", adr, 8'h20 + k);
          check_eq("bp_dat_o", dat_o, 32'hA0 + k);
          give_ack(0, 32'h0);
          wait_rsp("bp_wait_rsp");
          check_eq("bp_rsp_op", rsp_op, OP_WR_RSP);
          check_eq("bp_rsp_addr", rsp_addr, 32'h20 + k);
          check_eq("bp_rsp_data", rsp_data, 32'h0);
        end
      end
    join
    check_eq("bp_stall_seen", stall_seen, 1);
    repeat (2) @(negedge clk);
    check_eq("bp_stall_clear", req_stall, 0);

    // Response stall holds fields and blocks the next request
    rsp_stall = 1'b1;
    send_req(0, OP_WR, 32'h10, 32'h55);
    send_req(0, OP_RD, 32'h11, 32'h0);
    wait_cyc("rs_wait_cyc");
    give_ack(0, 32'h0);
    wait_rsp("rs_wait_rsp");
    h_op = rsp_op; h_addr = rsp_addr; h_data = rsp_data;
    check_eq("rs_op", h_op, OP_WR_RSP);
    check_eq("rs_addr", h_addr, 32'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("rs_hold_valid", rsp_valid, 1);
      check_eq("rs_hold_op", rsp_op, h_op);
      check_eq("rs_hold_addr", rsp_addr, h_addr);
      check_eq("rs_hold_data", rsp_data, h_data);
      check_eq("rs_no_next_cyc", cyc, 0);
    end
    rsp_stall = 1'b0;
    @(negedge clk);
    check_eq("rs_valid_drop", rsp_valid, 0);
    check_eq("rs_idle_cyc", cyc, 0);
    @(negedge clk);
    check_eq("rs_next_cyc", cyc, 1);
    check_eq("rs_next_adr", adr, 8'h11);
    give_ack(0, 32'hCAFE_0011);
    wait_rsp("rs2_wait_rsp");
    check_eq("rs2_op", rsp_op, OP_RD_RSP);
    check_eq("rs2_data", rsp_data, 32'hCAFE_0011);
    repeat (2) @(negedge clk);

    // Timeout on the TIMEOUT=8 instance
    send_req(1, OP_RD, 32'h55, 32'h0);
    n_cyc = 0; n_err = 0; n_rsp = 0;
    h_op = '0; h_addr = '0; h_data = '0;
    for (int k = 0; k < 14; k++) begin
      if (t_cyc) n_cyc++;
      if (t_tmo_err) n_err++;
      if (t_rsp_valid) begin
        n_rsp++;
        h_op = t_rsp_op; h_addr = t_rsp_addr; h_data = t_rsp_data;
      end
      @(negedge clk);
    end
    check_eq("to_cyc_cycles", n_cyc, 8);
    check_eq("to_err_pulses", n_err, 1);
    check_eq("to_rsp_count", n_rsp, 1);
    check_eq("to_rsp_op", h_op, OP_RD_RSP);
    check_eq("to_rsp_addr", h_addr, 32'h55);
    check_eq("to_rsp_data", h_data, 32'hDEAD_BEEF);
    check_eq("to_main_idle", cyc, 0);

    // Reset in the middle of a bus cycle with two entries queued
    send_req(0, OP_WR, 32'h40, 32'h1);
    send_req(0, OP_WR, 32'h41, 32'h2);
    send_req(0, OP_WR, 32'h42, 32'h3);
    wait_cyc("mr_wait_cyc");
    rst = 1'b1;
    #1;
    check_eq("mr_cyc", cyc, 0);
    check_eq("mr_stb", stb, 0);
    check_eq("mr_rsp_valid", rsp_valid, 0);
    check_eq("mr_stall", req_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cyc || rsp_valid) seen = 1'b1;
    end
    check_eq("mr_no_activity", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
